// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped, write-through cache controller.
// Word addresses split as {tag[TW], index[IW], offset[OFF_W]}.
package cache_pkg;

    localparam int WIDTH           = 32;
    localparam int DEPTH           = 1024;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int LINES           = 16;
    localparam int MEM_LAT         = 5;

    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(LINES);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int TW    = AW - IW - OFF_W;
    localparam int BW    = WIDTH * WORDS_PER_BLOCK;
    localparam int CNT_W = $clog2(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
        logic [BW-1:0] data;
    } line_t;

    function automatic logic [TW-1:0] addr_tag(input logic [AW-1:0] a);
        return a[AW-1 -: TW];
    endfunction

    function automatic logic [IW-1:0] addr_index(input logic [AW-1:0] a);
        return a[OFF_W +: IW];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [AW-1:0] a);
        return a[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/cache_array.sv
// Tag / valid / data storage for the cache.
//   rd_index_i            combinational read of one line (valid, tag, block)
//   line_we_i + line_*    whole-line fill: writes tag and block, sets valid
//   word_we_i + word_*    single-word update of a resident line's data
// Only the valid bits are reset; tag and data contents are meaningless until
// their line is filled.
module cache_array
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [IW-1:0]    rd_index_i,
    output logic             rd_valid_o,
    output logic [TW-1:0]    rd_tag_o,
    output logic [BW-1:0]    rd_data_o,
    input  logic             line_we_i,
    input  logic [IW-1:0]    line_index_i,
    input  logic [TW-1:0]    line_tag_i,
    input  logic [BW-1:0]    line_data_i,
    input  logic             word_we_i,
    input  logic [IW-1:0]    word_index_i,
    input  logic [OFF_W-1:0] word_off_i,
    input  logic [WIDTH-1:0] word_data_i
);

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [BW-1:0]    data_q [LINES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else if (line_we_i) begin
            valid_q[line_index_i] <= 1'b1;
        end
    end

    // A fill and a word update never coincide; the fill wins if they did.
    always_ff @(posedge clk) begin
        if (line_we_i) begin
            tag_q[line_index_i]  <= line_tag_i;
            data_q[line_index_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[word_index_i][word_off_i*WIDTH +: WIDTH] <= word_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache between the core's
// load/store port and main_mem.
//   cpu_*   core side: request, store flag, word address, store data,
//           load data (valid on a non-stalled load), stall
//   mem_*   main_mem side: ren, wen, word address, write data, read block
// Read hits return in the request cycle. Misses and every store run a
// fixed-latency main_mem operation with the core stalled throughout.
//
// state | meaning
// IDLE  | serve load hits; launch fill on load miss, write on store
// FILL  | mem_ren held MEM_LAT cycles, block captured in the last one
// WRITE | mem_wen held MEM_LAT cycles, resident word updated in the last one
module cache_ctrl
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [BW-1:0]    mem_rblock
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [TW-1:0]    tag;
    logic [IW-1:0]    index;
    logic [OFF_W-1:0] off;
    logic             rd_valid;
    logic [TW-1:0]    rd_tag;
    logic [BW-1:0]    rd_data;
    line_t            line;
    logic             hit;
    logic             last;
    logic             line_we;
    logic             word_we;

    assign tag   = addr_tag(cpu_addr);
    assign index = addr_index(cpu_addr);
    assign off   = addr_off(cpu_addr);

    cache_array u_array (
        .clk          (clk),
        .rstn         (rstn),
        .rd_index_i   (index),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data),
        .line_we_i    (line_we),
        .line_index_i (index),
        .line_tag_i   (tag),
        .line_data_i  (mem_rblock),
        .word_we_i    (word_we),
        .word_index_i (index),
        .word_off_i   (off),
        .word_data_i  (cpu_wdata)
    );

    assign line = {rd_valid, rd_tag, rd_data};
    assign hit  = line.valid && (line.tag == tag);
    assign last = (cnt_q == CNT_W'(MEM_LAT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        done_d    = 1'b0;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        line_we   = 1'b0;
        word_we   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        // The core re-presents a finished store for one cycle
                        // so it can retire; done_q stops it being issued twice.
                        if (!done_q) begin
                            cpu_stall = 1'b1;
                            state_d   = WRITE;
                        end
                    end else if (hit) begin
                        cpu_rdata = line.data[off*WIDTH +: WIDTH];
                    end else begin
                        cpu_stall = 1'b1;
                        state_d   = FILL;
                    end
                end
            end

            FILL: begin
                cpu_stall = 1'b1;
                mem_ren   = 1'b1;
                mem_addr  = {tag, index, {OFF_W{1'b0}}};
                cnt_d     = cnt_q + 1'b1;
                if (last) begin
                    line_we = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            WRITE: begin
                cpu_stall = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cnt_d     = cnt_q + 1'b1;
                if (last) begin
                    // No-write-allocate: only a resident line is touched.
                    word_we = hit;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
    import cache_pkg::*;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cpu_req = 1'b0;
    logic             cpu_we = 1'b0;
    logic [AW-1:0]    cpu_addr = '0;
    logic [WIDTH-1:0] cpu_wdata = '0;
    logic [WIDTH-1:0] cpu_rdata;
    logic             cpu_stall;
    logic             mem_ren;
    logic             mem_wen;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [BW-1:0]    mem_rblock;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rblock (mem_rblock)
    );

    function automatic logic [WIDTH-1:0] init_word(input int a);
        case (a)
            4:       return 32'h0000_0011;
            5:       return 32'h0000_0022;
            6:       return 32'h0000_0033;
            7:       return 32'h0000_0044;
            default: return 32'h5A00_0000 + 32'(a) * 32'h0001_0003;
        endcase
    endfunction

    // main_mem: block valid in the MEM_LAT-th ren cycle, write committed at
    // the end of the MEM_LAT-th wen cycle; garbage on r_block otherwise.
    logic [WIDTH-1:0] bmem [DEPTH];
    logic             mem_loaded = 1'b0;
    int               ren_cnt = 0;
    int               wen_cnt = 0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) bmem[i] <= init_word(i);
            mem_loaded <= 1'b1;
            mem_rblock <= {WORDS_PER_BLOCK{32'hBAD0_F00D}};
        end else begin
            ren_cnt <= mem_ren ? ren_cnt + 1 : 0;
            wen_cnt <= mem_wen ? wen_cnt + 1 : 0;
            if (mem_wen && wen_cnt == MEM_LAT - 1) bmem[mem_addr] <= mem_wdata;
            if (mem_ren && ren_cnt == MEM_LAT - 2) begin
                for (int w = 0; w < WORDS_PER_BLOCK; w++)
                    mem_rblock[w*WIDTH +: WIDTH] <= bmem[int'(mem_addr) + w];
            end else begin
                mem_rblock <= {WORDS_PER_BLOCK{32'hBAD0_F00D}};
            end
        end
    end

    // Reference model: expected memory contents and which tag each line holds.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int               res_tag [LINES];

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) res_tag[i] = -1;
    endtask

    task automatic model_expect(input logic we, input int a, output int st, output int rn,
                                output int wn, output logic [WIDTH-1:0] rd);
        int idx, tg;
        idx = (a / WORDS_PER_BLOCK) % LINES;
        tg  = a / (WORDS_PER_BLOCK * LINES);
        if (we) begin
            st = MEM_LAT + 1; rn = 0; wn = MEM_LAT;
        end else if (res_tag[idx] == tg) begin
            st = 0; rn = 0; wn = 0;
        end else begin
            st = MEM_LAT + 1; rn = MEM_LAT; wn = 0;
        end
        rd = ref_mem[a];
    endtask

    task automatic model_apply(input logic we, input int a, input logic [WIDTH-1:0] wd);
        if (we) ref_mem[a] = wd;
        else res_tag[(a / WORDS_PER_BLOCK) % LINES] = a / (WORDS_PER_BLOCK * LINES);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic access(input logic we, input int a, input logic [WIDTH-1:0] wd,
                          output int n_stall, output int n_ren, output int n_wen,
                          output logic [WIDTH-1:0] rd, output logic bus_ok,
                          output logic finished);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = AW'(a); cpu_wdata = wd;
        n_stall = 0; n_ren = 0; n_wen = 0; rd = '0; bus_ok = 1'b1; finished = 1'b0;
        for (int c = 0; c < 30 && !finished; c++) begin
            @(negedge clk);
            if (mem_ren && mem_wen) bus_ok = 1'b0;
            if (mem_ren) begin
                n_ren++;
                if (int'(mem_addr) != (a / WORDS_PER_BLOCK) * WORDS_PER_BLOCK) bus_ok = 1'b0;
            end
            if (mem_wen) begin
                n_wen++;
                if (int'(mem_addr) != a || mem_wdata != wd) bus_ok = 1'b0;
            end
            if (!cpu_stall) begin
                finished = 1'b1;
                rd = cpu_rdata;
            end else begin
                n_stall++;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic run_check(input string nm, input logic we, input int a, input logic [WIDTH-1:0] wd,
                             input int e_st, input int e_rn, input int e_wn, input logic [WIDTH-1:0] e_rd);
        int st, rn, wn;
        logic [WIDTH-1:0] rd;
        logic ok, fin;
        access(we, a, wd, st, rn, wn, rd, ok, fin);
        chk({nm, " completes"}, 32'(fin), 32'd1);
        chk({nm, " stall_cycles"}, 32'(st), 32'(e_st));
        chk({nm, " ren_cycles"}, 32'(rn), 32'(e_rn));
        chk({nm, " wen_cycles"}, 32'(wn), 32'(e_wn));
        chk({nm, " bus_addr_data"}, 32'(ok), 32'd1);
        if (we) chk({nm, " mem_word"}, bmem[a], wd);
        else    chk({nm, " rdata"}, rd, e_rd);
        model_apply(we, a, wd);
    endtask

    typedef struct {
        logic             we;
        int               addr;
        logic [WIDTH-1:0] wdata;
        int               stall;
        int               ren;
        int               wen;
        logic [WIDTH-1:0] rdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, rn, wn, n;
        logic [WIDTH-1:0] rd;
        logic we;
        int a;
        logic [WIDTH-1:0] wd;
        int tags [4];

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        model_reset();

        vecs.push_back('{1'b0, 'h004, 32'h0,          6, 5, 0, 32'h0000_0011});
        vecs.push_back('{1'b0, 'h006, 32'h0,          0, 0, 0, 32'h0000_0033});
        vecs.push_back('{1'b1, 'h005, 32'hDEAD_BEEF,  6, 0, 5, 32'h0});
        vecs.push_back('{1'b0, 'h005, 32'h0,          0, 0, 0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 'h3F0, 32'hCAFE_F00D,  6, 0, 5, 32'h0});
        vecs.push_back('{1'b0, 'h3F0, 32'h0,          6, 5, 0, 32'hCAFE_F00D});
        vecs.push_back('{1'b0, 'h044, 32'h0,          6, 5, 0, init_word('h044)});
        vecs.push_back('{1'b0, 'h004, 32'h0,          6, 5, 0, 32'h0000_0011});
        vecs.push_back('{1'b0, 'h044, 32'h0,          6, 5, 0, init_word('h044)});
        vecs.push_back('{1'b0, 'h3FF, 32'h0,          6, 5, 0, init_word('h3FF)});
        vecs.push_back('{1'b0, 'h000, 32'h0,          6, 5, 0, init_word('h000)});
        vecs.push_back('{1'b0, 'h004, 32'h0,          6, 5, 0, 32'h0000_0011});
        vecs.push_back('{1'b0, 'h007, 32'h0,          0, 0, 0, 32'h0000_0044});
        vecs.push_back('{1'b1, 'h007, 32'h1234_5678,  6, 0, 5, 32'h0});
        vecs.push_back('{1'b0, 'h007, 32'h0,          0, 0, 0, 32'h1234_5678});
        vecs.push_back('{1'b0, 'h3FC, 32'h0,          0, 0, 0, init_word('h3FC)});

        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("reset mem_ren", 32'(mem_ren), 32'd0);
        chk("reset mem_wen", 32'(mem_wen), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset cpu_stall", 32'(cpu_stall), 32'd0);
        chk("reset cpu_rdata", cpu_rdata, 32'd0);

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].stall, vecs[i].ren, vecs[i].wen, vecs[i].rdata);
        end

        // Reset in the third cycle of a fill aborts it and invalidates everything.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'('h100);
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (mem_ren) n++;
        end
        chk("midfill reached ren cycle 3", 32'(n), 32'd3);
        #2 rstn = 1'b0;
        #1;
        chk("midfill reset mem_ren", 32'(mem_ren), 32'd0);
        chk("midfill reset mem_wen", 32'(mem_wen), 32'd0);
        chk("midfill reset mem_addr", 32'(mem_addr), 32'd0);
        chk("midfill reset mem_wdata", mem_wdata, 32'd0);
        chk("midfill reset cpu_rdata", cpu_rdata, 32'd0);
        cpu_req = 1'b0;
        #1;
        chk("midfill reset cpu_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        run_check("reload 0x100 after abort", 1'b0, 'h100, 32'h0, 6, 5, 0, init_word('h100));
        run_check("0x004 invalid after reset", 1'b0, 'h004, 32'h0, 6, 5, 0, 32'h0000_0011);

        // Randomized traffic over a few tags to mix hits, conflicts and stores.
        tags[0] = 0; tags[1] = 1; tags[2] = 2; tags[3] = 15;
        for (int k = 0; k < 250; k++) begin
            we = ($urandom_range(0, 3) == 0);
            a  = tags[$urandom_range(0, 3)] * (WORDS_PER_BLOCK * LINES)
               + $urandom_range(0, LINES - 1) * WORDS_PER_BLOCK
               + $urandom_range(0, WORDS_PER_BLOCK - 1);
            wd = $urandom;
            model_expect(we, a, st, rn, wn, rd);
            run_check($sformatf("rand%0d", k), we, a, wd, st, rn, wn, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller sitting between the RISC-V core's load/store port and main_mem.
- Holds tag, valid and data arrays, and serves read hits in zero wait cycles.
- On misses and on every store, it sequences main_mem's fixed multi-cycle read-block and write-word operations.
- Stalls the core for the whole duration of each main_mem operation.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 1024, main memory depth in words; address width AW = clog2(DEPTH).
- WORDS_PER_BLOCK, 4, words per cache line; block width = WIDTH*WORDS_PER_BLOCK = 128.
- LINES, 16, number of cache lines; index width IW = clog2(LINES).
- MEM_LAT, 5, cycles from first ren/wen assertion to main_mem operation complete (r_block valid / write committed).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- cpu_req  in  1  core access request; core holds all cpu_* inputs stable while cpu_stall=1.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  AW  word address; fields are {tag, index[IW], offset[2]}.
- cpu_wdata  in  WIDTH  store data.
- cpu_rdata  out  WIDTH  load data, valid when cpu_req & !cpu_we & !cpu_stall.
- cpu_stall  out  1  core must hold its request and freeze its pipeline.
- mem_ren  out  1  to main_mem ren.
- mem_wen  out  1  to main_mem wen.
- mem_addr  out  AW  to main_mem addr (word address).
- mem_wdata  out  WIDTH  to main_mem w_data.
- mem_rblock  in  WIDTH*WORDS_PER_BLOCK  from main_mem r_block; word 0 sits in the least-significant bits.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, all valid bits=0, counter=0.
  - mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - cpu_stall=0, cpu_rdata=0.
  - Tag and data arrays need no reset.
- Reset asserted mid-operation aborts it. The partial fill is discarded (line stays invalid), and any pending write may or may not reach memory.
- States: IDLE, FILL, WRITE.
- IDLE:
  - hit = valid[index] & (tag_arr[index]==tag).
  - Load hit: cpu_rdata = data_arr[index] word[offset], combinational; cpu_stall=0; stay IDLE.
  - Load miss: cpu_stall=1 combinationally in the same cycle; next state FILL.
  - Store, hit or miss: cpu_stall=1; next state WRITE.
  - cpu_req=0: cpu_stall=0, no state change.
- FILL:
  - mem_ren=1, mem_addr={tag,index,2'b00}, both held constant.
  - Counter increments each cycle from 0.
  - At count==MEM_LAT-1: capture mem_rblock into data_arr[index], write tag_arr[index], set valid[index]; next state IDLE.
  - The request then hits in IDLE, so total load-miss latency is MEM_LAT+1 cycles.
  - mem_ren drops to 0 on leaving FILL.
- WRITE:
  - mem_wen=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, all held for MEM_LAT cycles.
  - At count==MEM_LAT-1: if the line is a hit, update data_arr[index] word[offset] with cpu_wdata (valid and tag unchanged). A miss allocates nothing.
  - Next state IDLE with cpu_stall=0 that cycle. The store retires when IDLE sees the same request again; the controller tracks a one-cycle "done" flag so the store is not repeated.
- mem_ren and mem_wen are never asserted together.
- The counter resets to 0 on every state entry.
- The controller never issues a back-to-back operation without returning through IDLE.
- Boundary cases:
  - Addresses 0 and DEPTH-1 map correctly; no wrap handling is needed.
  - A load following a store to the same line sees the updated word.
  - A fill of an index whose valid line has a different tag overwrites that line; write-through means nothing needs to be written back.

Decomposition:
- Package cache_pkg:
  - state_t enum {IDLE, FILL, WRITE}.
  - Address field widths and slice helper constants: OFF_W=2, IW, TW=AW-IW-2.
  - line_t struct {valid, tag, data}.
- One natural sub-module: cache_array (tag/valid/data storage with async-reset valid bits, one line write port, one word write port). The FSM stays in cache_ctrl.

Test Plan:
- Cold load from addr 0x004 after reset, with main_mem preloaded so mem[4..7]=0x11,0x22,0x33,0x44 -> cpu_stall high 6 cycles, mem_ren high 5 cycles with mem_addr=0x004, then cpu_rdata=0x11.
- Load addr 0x006 immediately after the previous test -> hit, cpu_stall=0, cpu_rdata=0x33, mem_ren stays 0.
- Store 0xDEADBEEF to 0x005 (line resident) -> mem_wen high 5 cycles with mem_addr=0x005; a following load of 0x005 hits and returns 0xDEADBEEF; mem[5]=0xDEADBEEF.
- Store to 0x3F0 (line not resident) -> memory is written, and a following load of 0x3F0 misses and fills with the stored value.
- Conflict: load 0x004, then load 0x044 (same index 1, different tag), then load 0x004 -> three misses, each with a 5-cycle mem_ren.
- Assert rstn=0 during cycle 3 of a FILL -> all outputs go to 0 immediately; a reload of the same address misses again.
